// File: rtl/otter_csr_intr.sv
// Machine-mode CSR file and external-interrupt front end for the OTTER MCU.
// Synchronizes/edge-latches INTR, gates it with MIE/MEIE, and handles trap entry and mret.
module otter_csr_intr (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic [11:0] ADDR,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] WD,
  input  logic        CSR_WE,
  input  logic        INT_TAKEN,
  input  logic        MRET_EXEC,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic [31:0] CSR_MTVEC,
  output logic [31:0] CSR_MEPC,
  output logic        CS_INTR
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic        sync1, sync2, sync3;
  logic        pending;
  logic        intr_edge;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_meie;
  logic [29:0] mtvec_q;
  logic [29:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] rd_val;
  logic [31:0] wval;
  logic        wr_en;

  // The low two PC bits never reach mepc (word-aligned return address).
  logic unused_ok;
  assign unused_ok = &{1'b0, PC[1:0]};

  assign intr_edge = sync2 & ~sync3;
  assign CS_INTR   = pending & mstatus_mie & mie_meie;
  assign CSR_MTVEC = {mtvec_q, 2'b00};
  assign CSR_MEPC  = {mepc_q, 2'b00};
  assign RD        = rd_val;

  always_comb begin
    rd_val = 32'h0;
    case (ADDR)
      ADDR_MSTATUS: rd_val = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      ADDR_MIE:     rd_val = {20'h0, mie_meie, 11'h0};
      ADDR_MTVEC:   rd_val = {mtvec_q, 2'b00};
      ADDR_MEPC:    rd_val = {mepc_q, 2'b00};
      ADDR_MCAUSE:  rd_val = mcause_q;
      ADDR_MIP:     rd_val = {20'h0, pending, 11'h0};
      default:      rd_val = 32'h0;
    endcase
  end

  // Read-modify-write operand; masks are applied when the field is stored.
  always_comb begin
    wval  = 32'h0;
    wr_en = 1'b0;
    case (FUNCT3)
      3'b001: begin wval = WD;              wr_en = CSR_WE; end
      3'b010: begin wval = rd_val | WD;     wr_en = CSR_WE; end
      3'b011: begin wval = rd_val & ~WD;    wr_en = CSR_WE; end
      default: begin wval = 32'h0;          wr_en = 1'b0;   end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      pending      <= 1'b0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec_q      <= 30'h0;
      mepc_q       <= 30'h0;
      mcause_q     <= 32'h0;
    end else begin
      sync1   <= INTR;
      sync2   <= sync1;
      sync3   <= sync2;
      // A fresh edge wins over the trap-entry clear so no request is lost.
      pending <= intr_edge | (pending & ~INT_TAKEN);
      if (INT_TAKEN) begin
        mepc_q       <= PC[31:2];
        mcause_q     <= 32'h8000_000B;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (wr_en) begin
        case (ADDR)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          ADDR_MIE:    mie_meie <= wval[11];
          ADDR_MTVEC:  mtvec_q  <= wval[31:2];
          ADDR_MEPC:   mepc_q   <= wval[31:2];
          ADDR_MCAUSE: mcause_q <= wval;
          default: ;
        endcase
      end else if (MRET_EXEC) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_otter_csr_intr.sv
// Directed testbench for otter_csr_intr: CSR ops, interrupt latency, trap/mret,
// masking, held INTR, edge/trap collision and reset behaviour.
module tb_otter_csr_intr;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INTR = 1'b0;
  logic [11:0] ADDR = 12'h0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] WD = 32'h0;
  logic        CSR_WE = 1'b0;
  logic        INT_TAKEN = 1'b0;
  logic        MRET_EXEC = 1'b0;
  logic [31:0] PC = 32'h0;
  logic [31:0] RD;
  logic [31:0] CSR_MTVEC;
  logic [31:0] CSR_MEPC;
  logic        CS_INTR;

  int checks = 0;
  int errors = 0;

  otter_csr_intr dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .ADDR(ADDR), .FUNCT3(FUNCT3), .WD(WD),
    .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC), .PC(PC),
    .RD(RD), .CSR_MTVEC(CSR_MTVEC), .CSR_MEPC(CSR_MEPC), .CS_INTR(CS_INTR)
  );

  always #10 CLK = ~CLK;

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    chk(tag, RD, exp);
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d);
    ADDR = a; FUNCT3 = f3; WD = d; CSR_WE = 1'b1;
    step();
    CSR_WE = 1'b0; FUNCT3 = 3'b000; WD = 32'h0;
  endtask

  task automatic trap(input logic [31:0] pc_val);
    PC = pc_val; INT_TAKEN = 1'b1;
    step();
    INT_TAKEN = 1'b0;
  endtask

  task automatic mret();
    MRET_EXEC = 1'b1;
    step();
    MRET_EXEC = 1'b0;
  endtask

  initial begin
    step(); step();
    RST = 1'b0;
    step();

    // Fill every CSR with ones; reads show the field masks.
    csr_op(12'h300, 3'b001, 32'hFFFF_FFFF);
    csr_op(12'h304, 3'b001, 32'hFFFF_FFFF);
    csr_op(12'h305, 3'b001, 32'hFFFF_FFFF);
    csr_op(12'h341, 3'b001, 32'hFFFF_FFFF);
    csr_op(12'h342, 3'b001, 32'hFFFF_FFFF);
    rd_chk("mask_mstatus", 12'h300, 32'h0000_0088);
    rd_chk("mask_mie",     12'h304, 32'h0000_0800);
    rd_chk("mask_mtvec",   12'h305, 32'hFFFF_FFFC);
    rd_chk("mask_mepc",    12'h341, 32'hFFFF_FFFC);
    rd_chk("mask_mcause",  12'h342, 32'hFFFF_FFFF);

    RST = 1'b1;
    step();
    RST = 1'b0;
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mie",     12'h304, 32'h0);
    rd_chk("rst_mtvec",   12'h305, 32'h0);
    rd_chk("rst_mepc",    12'h341, 32'h0);
    rd_chk("rst_mcause",  12'h342, 32'h0);
    rd_chk("rst_mip",     12'h344, 32'h0);
    chk("rst_cs_intr",   {31'h0, CS_INTR}, 32'h0);
    chk("rst_csr_mtvec", CSR_MTVEC, 32'h0);
    chk("rst_csr_mepc",  CSR_MEPC, 32'h0);

    // csrrw mtvec: RD returns the pre-write value during the write cycle.
    ADDR = 12'h305; FUNCT3 = 3'b001; WD = 32'h0000_0107; CSR_WE = 1'b1;
    #1;
    chk("csrrw_rd_old", RD, 32'h0);
    step();
    CSR_WE = 1'b0; FUNCT3 = 3'b000;
    chk("csrrw_mtvec_out", CSR_MTVEC, 32'h0000_0104);
    rd_chk("csrrw_mtvec_rd", 12'h305, 32'h0000_0104);

    csr_op(12'h300, 3'b010, 32'h0000_0008);
    rd_chk("csrrs_mstatus", 12'h300, 32'h0000_0008);
    csr_op(12'h300, 3'b011, 32'h0000_0008);
    rd_chk("csrrc_mstatus", 12'h300, 32'h0);
    csr_op(12'h305, 3'b000, 32'hFFFF_FFFF);
    chk("f3_000_nowrite", CSR_MTVEC, 32'h0000_0104);

    // Enabled interrupt: CS_INTR high after the third edge from INTR rising.
    csr_op(12'h300, 3'b010, 32'h0000_0008);
    csr_op(12'h304, 3'b010, 32'h0000_0800);
    INTR = 1'b1;
    step();
    INTR = 1'b0;
    chk("lat_edge_k",  {31'h0, CS_INTR}, 32'h0);
    step();
    chk("lat_edge_k1", {31'h0, CS_INTR}, 32'h0);
    step();
    chk("lat_edge_k2", {31'h0, CS_INTR}, 32'h1);

    trap(32'h0000_0123);
    chk("trap_cs_intr", {31'h0, CS_INTR}, 32'h0);
    chk("trap_mepc_out", CSR_MEPC, 32'h0000_0120);
    rd_chk("trap_mcause",  12'h342, 32'h8000_000B);
    rd_chk("trap_mstatus", 12'h300, 32'h0000_0080);
    rd_chk("trap_mip",     12'h344, 32'h0);

    mret();
    rd_chk("mret_mstatus", 12'h300, 32'h0000_0088);

    // INTR held high yields exactly one request.
    INTR = 1'b1;
    step(); step(); step();
    chk("hold_first_req", {31'h0, CS_INTR}, 32'h1);
    trap(32'h0000_0200);
    mret();
    step(); step(); step(); step();
    chk("hold_no_second", {31'h0, CS_INTR}, 32'h0);
    rd_chk("hold_mip_clear", 12'h344, 32'h0);
    INTR = 1'b0;
    step(); step(); step();
    INTR = 1'b1;
    step(); step(); step();
    chk("retoggle_req", {31'h0, CS_INTR}, 32'h1);
    trap(32'h0000_0300);
    INTR = 1'b0;
    step(); step(); step();

    // Masked: pending remains visible in mip until software enables MIE.
    rd_chk("mask_mie_off", 12'h300, 32'h0000_0080);
    INTR = 1'b1;
    step();
    INTR = 1'b0;
    step(); step(); step();
    rd_chk("masked_mip", 12'h344, 32'h0000_0800);
    chk("masked_cs_intr", {31'h0, CS_INTR}, 32'h0);
    csr_op(12'h344, 3'b011, 32'h0000_0800);
    rd_chk("mip_readonly", 12'h344, 32'h0000_0800);
    csr_op(12'h300, 3'b010, 32'h0000_0008);
    chk("unmask_cs_intr", {31'h0, CS_INTR}, 32'h1);
    trap(32'h0000_0400);
    rd_chk("unmask_trap_mip", 12'h344, 32'h0);

    // Collision: edge reaches pending on the same edge as INT_TAKEN.
    INTR = 1'b1;
    step();
    step();
    trap(32'h0000_0500);
    INTR = 1'b0;
    rd_chk("collision_mip", 12'h344, 32'h0000_0800);
    chk("collision_mepc", CSR_MEPC, 32'h0000_0500);

    csr_op(12'h123, 3'b001, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 12'h123, 32'h0);
    chk("unmapped_mtvec", CSR_MTVEC, 32'h0000_0104);

    // Reset mid-request discards the pending interrupt.
    RST = 1'b1;
    step();
    RST = 1'b0;
    rd_chk("rst_pending_mip", 12'h344, 32'h0);
    chk("rst_pending_mepc", CSR_MEPC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_csr_intr.md
# otter_csr_intr

Machine-mode CSR file and external-interrupt front end for the OTTER MCU. Synchronizes and edge-latches the external interrupt line, gates it with the mstatus/mie enables, and drives CS_INTR into the control-unit FSM. Consumes the FSM's csr_WE, int_taken and mret_exec strobes, and supplies the trap vector (mtvec) and return address (mepc) to the PC-select mux.

## Interface
- No parameters. CSR set and widths are fixed.
- CLK  in  1  system clock; all state updates on its rising edge
- RST  in  1  synchronous, active-high reset
- INTR  in  1  external interrupt request, asynchronous to CLK
- ADDR  in  12  CSR address, IR[31:20]
- FUNCT3  in  3  CSR op, IR[14:12]: 001 csrrw, 010 csrrs, 011 csrrc
- WD  in  32  write operand (rs1 value)
- CSR_WE  in  1  CSR write strobe from the FSM
- INT_TAKEN  in  1  trap-entry strobe from the FSM
- MRET_EXEC  in  1  mret strobe from the FSM
- PC  in  32  address of the current instruction; saved to mepc on trap entry
- RD  out  32  combinational read of the CSR at ADDR, written to rd
- CSR_MTVEC  out  32  current mtvec
- CSR_MEPC  out  32  current mepc
- CS_INTR  out  1  interrupt request to the FSM

## Operation
- CSR map:
  - 0x300 mstatus: bit 3 MIE, bit 7 MPIE; all other bits read 0.
  - 0x304 mie: bit 11 MEIE only.
  - 0x305 mtvec: bits [1:0] read 0.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause: full 32 bits.
  - 0x344 mip: read-only, bit 11 = pending.
  - Unmapped address: reads 0, writes ignored.
- Write value when CSR_WE=1:
  - csrrw: WD.
  - csrrs: old | WD.
  - csrrc: old & ~WD.
  - Any other FUNCT3: no write.
  - Write masks apply after the op.
  - RD always returns the pre-write value.
- Interrupt path:
  - sync1 ← INTR, then sync2 ← sync1, then sync3 ← sync2.
  - edge = sync2 & ~sync3.
  - pending sets on edge. It clears on INT_TAKEN, or on a csrrc to mip address is ignored (mip is read-only).
  - CS_INTR = pending & MIE & MEIE (combinational).
- Trap entry on INT_TAKEN:
  - mepc ← {PC[31:2],2'b00}
  - mcause ← 0x8000000B
  - MPIE ← MIE, MIE ← 0
  - pending ← 0
- MRET_EXEC: MIE ← MPIE, MPIE ← 1.
- Priority within one cycle:
  - INT_TAKEN over CSR_WE over MRET_EXEC; the FSM never asserts these together.
  - An edge in the same cycle as INT_TAKEN leaves pending set, so a request is never lost.
- Repeated edges while pending is set: pending stays 1, no counting.
- INTR held high: one request only; a new request needs low then high.

## Timing
- Reset (RST=1 at an edge): every CSR, sync1-3 and pending go to 0; CS_INTR=0, RD=0 for any ADDR, CSR_MTVEC=0, CSR_MEPC=0. Reset mid-request discards the pending interrupt.
- INTR latency: INTR rises before edge k. Then sync1=1 after k, sync2=1 after k+1, pending=1 after k+2. CS_INTR goes high in the cycle after edge k+2 if enabled.
- CSR writes, trap entry and mret take effect at the clock edge where the strobe is high. They are visible on RD, CS_INTR, CSR_MTVEC and CSR_MEPC in the next cycle.
- CS_INTR drops in the cycle after INT_TAKEN, because MIE and pending are both cleared.
- Masked interrupt: pending stays set. CS_INTR rises the cycle after MIE and MEIE are both set by software.

## Test plan
- Reset: write 0xFFFFFFFF to all CSRs, pulse RST → all reads 0, CS_INTR=0, CSR_MTVEC=0.
- CSR ops:
  - csrrw 0x305 WD=0x00000107 → RD shows old value that cycle; next cycle CSR_MTVEC=0x00000104.
  - csrrs 0x300 WD=0x8 → mstatus=0x8.
  - csrrc 0x300 WD=0x8 → mstatus=0.
- Interrupt flow:
  - Setup: MIE=1, MEIE=1; pulse INTR high 1 cycle → CS_INTR high exactly 3 edges later.
  - INT_TAKEN with PC=0x00000123 → mepc=0x00000120, mcause=0x8000000B, mstatus=0x80, CS_INTR=0 next cycle.
- mret after trap → mstatus=0x88. Hold INTR high throughout → no second CS_INTR until INTR toggles low then high.
- Masked: MIE=0, INTR edge → mip=0x800, CS_INTR=0. Then set MIE via csrrs → CS_INTR=1 next cycle.
- Collision: INTR edge reaches pending in the same cycle as INT_TAKEN → pending remains 1. An unmapped write (0x123) reads back 0.
